// File: rtl/bcd_key_entry_v_pkg.sv
// bcd_key_entry_v_pkg: shared widths, entry FSM encoding and key priority encoder
package bcd_key_entry_v_pkg;
  localparam int BCD_W = 4;
  localparam int NUM_KEYS = 10;
  localparam int KEY_W = NUM_KEYS + 1;
  typedef enum logic [2:0] {
    S_A1   = 3'd0,
    S_A0   = 3'd1,
    S_B1   = 3'd2,
    S_B0   = 3'd3,
    S_DONE = 3'd4
  } entry_state_t;
  function automatic logic [BCD_W-1:0] top_key(input logic [NUM_KEYS-1:0] k);
    top_key = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      if (k[i]) top_key = BCD_W'(i);
  endfunction
endpackage

// File: rtl/bcd_key_entry_v_debounce.sv
// key_debounce_v: 2-FF synchroniser, shared stability counter, stable image and rollover-locked press pulse
module key_debounce_v #(
  parameter int DB_CYCLES = 1000,
  parameter int DB_CNT_W  = 10,
  parameter int WIDTH     = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] stable_o,
  output logic             press_o
);
  localparam logic [DB_CNT_W-1:0] CNT_MAX = DB_CNT_W'(DB_CYCLES - 1);
  logic [WIDTH-1:0] sync1_q, sync2_q, prev_q, stable_q;
  logic [DB_CNT_W-1:0] cnt_q, cnt_d;
  logic sat, armed_q, armed_d, press_q, press_d;
  // armed only after an all-released image is accepted, so a key held through reset or rollover never fires
  always_comb begin
    sat = cnt_q == CNT_MAX;
    cnt_d = sync2_q != prev_q ? '0 : sat ? cnt_q : cnt_q + 1'b1;
    armed_d = sat ? &prev_q : armed_q;
    press_d = sat && armed_q && !(&prev_q);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      prev_q   <= '1;
      stable_q <= '1;
      cnt_q    <= '0;
      armed_q  <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
      if (sat) stable_q <= prev_q;
      armed_q <= armed_d;
      press_q <= press_d;
    end
  assign stable_o = stable_q;
  assign press_o  = press_q;
endmodule

// File: rtl/bcd_key_entry_v.sv
// bcd_key_entry_v: debounced keypad front end assembling two 2-digit BCD operands for the adder stage
module bcd_key_entry_v
  import bcd_key_entry_v_pkg::*;
#(
  parameter int DB_CYCLES = 1000,
  parameter int DB_CNT_W  = 10
) (
  input  logic                CLK,
  input  logic                CLR,
  input  logic [NUM_KEYS-1:0] KEYn,
  input  logic                EQUALn,
  output logic [7:0]          A_BCD,
  output logic [7:0]          B_BCD,
  output logic [BCD_W-1:0]    DIGIT,
  output logic                DIGIT_STB,
  output logic                OPS_READY,
  output logic                EQ_STB,
  output logic [2:0]          ENTRY_STATE
);
  logic [1:0] rst_q;
  logic rst, press, dig, eq;
  logic [KEY_W-1:0] img;
  logic [NUM_KEYS-1:0] keys;
  logic [BCD_W-1:0] d;
  entry_state_t state_q;
  logic [7:0] a_q, b_q;
  logic [BCD_W-1:0] digit_q;
  logic dstb_q, ops_q, eq_q;
  always_ff @(posedge CLK or posedge CLR)
    if (CLR) rst_q <= 2'b11;
    else rst_q <= {rst_q[0], 1'b0};
  assign rst = rst_q[1];
  key_debounce_v #(
    .DB_CYCLES(DB_CYCLES),
    .DB_CNT_W (DB_CNT_W),
    .WIDTH    (KEY_W)
  ) u_db (
    .clk     (CLK),
    .rst     (rst),
    .raw_i   ({EQUALn, KEYn}),
    .stable_o(img),
    .press_o (press)
  );
  assign keys = ~img[NUM_KEYS-1:0];
  assign d    = top_key(keys);
  assign dig  = press && |keys;
  assign eq   = press && !img[NUM_KEYS] && !dig;
  always_ff @(posedge CLK or posedge rst)
    if (rst) begin
      state_q <= S_A1;
      a_q     <= '0;
      b_q     <= '0;
      digit_q <= '0;
      dstb_q  <= 1'b0;
      ops_q   <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      dstb_q <= dig;
      eq_q   <= eq && state_q == S_DONE;
      if (dig) begin
        digit_q <= d;
        case (state_q)
          S_A1: begin
            a_q     <= {d, 4'd0};
            state_q <= S_A0;
          end
          S_A0: begin
            a_q[3:0] <= d;
            state_q  <= S_B1;
          end
          S_B1: begin
            b_q     <= {d, 4'd0};
            state_q <= S_B0;
          end
          S_B0: begin
            b_q[3:0] <= d;
            state_q  <= S_DONE;
            ops_q    <= 1'b1;
          end
          default: begin
            a_q     <= {d, 4'd0};
            b_q     <= '0;
            state_q <= S_A0;
            ops_q   <= 1'b0;
          end
        endcase
      end
    end
  assign A_BCD       = a_q;
  assign B_BCD       = b_q;
  assign DIGIT       = digit_q;
  assign DIGIT_STB   = dstb_q;
  assign OPS_READY   = ops_q;
  assign EQ_STB      = eq_q;
  assign ENTRY_STATE = state_q;
endmodule
